// File: rtl/xrv1_imem_arb.sv
// Two-port arbiter in front of the instruction memory: fetch (p0) and data/loader (p1).
// Build option XRV1_IMEM_ARB_RR_EN selects round-robin arbitration; otherwise p1 has fixed priority.
module xrv1_imem_arb #(
    parameter  int max_outstanding_p = 4,
    localparam int cnt_width_lp      = $clog2(max_outstanding_p + 1)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        p0_req_vld_i,
    output logic        p0_req_rdy_o,
    input  logic [31:0] p0_req_addr_i,
    input  logic        p0_flush_i,
    output logic        p0_resp_vld_o,
    output logic [31:0] p0_resp_data_o,
    input  logic        p1_req_vld_i,
    output logic        p1_req_rdy_o,
    input  logic [31:0] p1_req_addr_i,
    input  logic        p1_req_we_i,
    input  logic [3:0]  p1_req_be_i,
    input  logic [31:0] p1_req_wdata_i,
    output logic        p1_resp_vld_o,
    output logic [31:0] p1_resp_data_o,
    output logic        mem_req_vld_o,
    input  logic        mem_req_rdy_i,
    output logic [31:0] mem_req_addr_o,
    output logic        mem_req_we_o,
    output logic [3:0]  mem_req_be_o,
    output logic [31:0] mem_req_wdata_o,
    input  logic        mem_resp_vld_i,
    input  logic [31:0] mem_resp_data_i
);

    localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam logic [cnt_width_lp-1:0] max_cnt_lp  = cnt_width_lp'(max_outstanding_p);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(max_outstanding_p - 1);

    // Route FIFO: one {port, kill} entry per request in flight, oldest at head.
    logic [max_outstanding_p-1:0] port_q, port_d, kill_q, kill_d;
    logic [ptr_width_lp-1:0]      head_q, head_d, tail_q, tail_d;
    logic [cnt_width_lp-1:0]      count_q, count_d;
    logic                         lock_q, lock_d;
    logic                         lock_port_q, lock_port_d;
    logic                         rr_q, rr_d;

    logic pop, push, issue_ok, elig0, elig1, gnt, pick, req_vld;
    logic head_port, kill_eff;

    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop       = mem_resp_vld_i & (count_q != '0);
        head_port = port_q[head_q];
        kill_eff  = kill_q[head_q] | (p0_flush_i & ~head_port);
        // A pop in the same cycle frees a slot, so a full FIFO can still issue.
        issue_ok  = (count_q < max_cnt_lp) | pop;
        elig0     = p0_req_vld_i & ~p0_flush_i;
        elig1     = p1_req_vld_i;
`ifdef XRV1_IMEM_ARB_RR_EN
        pick      = rr_q;
`else
        pick      = 1'b1;
`endif
        // A flushed p0 is ineligible, which drops its lock and lets arbitration rerun.
        if (lock_q && (lock_port_q ? elig1 : elig0)) begin
            gnt = lock_port_q;
        end else if (elig0 && elig1) begin
            gnt = pick;
        end else begin
            gnt = elig1;
        end
        req_vld = issue_ok & (elig0 | elig1);
        push    = req_vld & mem_req_rdy_i;

        port_d  = port_q;
        kill_d  = kill_q | (~port_q & {max_outstanding_p{p0_flush_i}});
        head_d  = head_q;
        tail_d  = tail_q;
        if (push) begin
            port_d[tail_q] = gnt;
            kill_d[tail_q] = 1'b0;
            tail_d         = next_ptr(tail_q);
        end
        if (pop) begin
            head_d = next_ptr(head_q);
        end
        count_d     = count_q + cnt_width_lp'(push) - cnt_width_lp'(pop);
        lock_d      = req_vld & ~mem_req_rdy_i;
        lock_port_d = gnt;
        rr_d        = push ? ~gnt : rr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            port_q      <= '0;
            kill_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            lock_q      <= 1'b0;
            lock_port_q <= 1'b0;
            rr_q        <= 1'b1;
        end else begin
            port_q      <= port_d;
            kill_q      <= kill_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
            rr_q        <= rr_d;
        end
    end

    always_comb begin
        mem_req_vld_o   = req_vld & ~rst_i;
        mem_req_addr_o  = gnt ? p1_req_addr_i : {p0_req_addr_i[31:2], 2'b00};
        mem_req_we_o    = gnt & p1_req_we_i;
        mem_req_be_o    = gnt ? p1_req_be_i : 4'hf;
        mem_req_wdata_o = gnt ? p1_req_wdata_i : 32'h0;
        p0_req_rdy_o    = push & ~gnt & ~rst_i;
        p1_req_rdy_o    = push & gnt & ~rst_i;
        p0_resp_vld_o   = pop & ~head_port & ~kill_eff & ~rst_i;
        p1_resp_vld_o   = pop & head_port & ~rst_i;
        p0_resp_data_o  = mem_resp_data_i;
        p1_resp_data_o  = mem_resp_data_i;
    end

    // A response with nothing in flight has no owner and is dropped.
    resp_without_request_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mem_resp_vld_i && (count_q == '0)));

    // Rotation state is only consumed in round-robin builds.
    logic unused_rr;
    assign unused_rr = rr_q;

endmodule
